// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared opcodes, default widths and command-word field
//               position helpers for the fully associative cache.
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    // Command opcodes carried in the MSBs of vector_in
    localparam logic [1:0] OP_FLUSH = 2'b00;
    localparam logic [1:0] OP_READ  = 2'b01;
    localparam logic [1:0] OP_WRITE = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    // Default geometry
    localparam int C_TAG_WIDTH     = 8;
    localparam int C_DATA_WIDTH    = 16;
    localparam int C_ENTRIES_WIDTH = 64;
    localparam int C_OPCODE_WIDTH  = 2;

    // vector_in = {opcode, tag, data}; these return the LSB of each field
    function automatic int opcode_lsb(input int tag_w, input int data_w);
        return tag_w + data_w;
    endfunction

    function automatic int tag_lsb(input int data_w);
        return data_w;
    endfunction

    function automatic int data_lsb();
        return 0;
    endfunction

endpackage : cache_pkg
`default_nettype wire

// File: rtl/cache_match.sv
`default_nettype none
// ============================================================================
// Module      : cache_match
// Description : Combinational parallel tag compare over all valid entries,
//               plus lowest-index free-entry search.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_match
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH     = C_TAG_WIDTH,
    parameter int ENTRIES_WIDTH = C_ENTRIES_WIDTH,
    localparam int IDX_WIDTH    = $clog2(ENTRIES_WIDTH)
) (
    input  logic [ENTRIES_WIDTH-1:0]                i_valid,
    input  logic [ENTRIES_WIDTH-1:0][TAG_WIDTH-1:0] i_tags,
    input  logic [TAG_WIDTH-1:0]                    i_lookup_tag,
    output logic                                    o_hit,
    output logic [IDX_WIDTH-1:0]                    o_hit_index,
    output logic                                    o_free_found,
    output logic [IDX_WIDTH-1:0]                    o_first_free_index
);

    // Scan upward; the first match/free slot found wins, giving lowest index
    always_comb begin
        o_hit              = 1'b0;
        o_hit_index        = '0;
        o_free_found       = 1'b0;
        o_first_free_index = '0;
        for (int i = 0; i < ENTRIES_WIDTH; i++) begin
            if (!o_hit && i_valid[i] && (i_tags[i] == i_lookup_tag)) begin
                o_hit       = 1'b1;
                o_hit_index = i[IDX_WIDTH-1:0];
            end
            if (!o_free_found && !i_valid[i]) begin
                o_free_found       = 1'b1;
                o_first_free_index = i[IDX_WIDTH-1:0];
            end
        end
    end

endmodule : cache_match
`default_nettype wire

// File: rtl/cache.sv
`default_nettype none
// ============================================================================
// Module      : cache
// Description : Fully associative tag/data cache, one command per clock.
//               Optional hit/miss statistics counters when CACHE_STATS_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module cache
    import cache_pkg::*;
#(
    parameter int TAG_WIDTH     = C_TAG_WIDTH,
    parameter int DATA_WIDTH    = C_DATA_WIDTH,
    parameter int ENTRIES_WIDTH = C_ENTRIES_WIDTH,
    parameter int OPCODE_WIDTH  = C_OPCODE_WIDTH
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      enable,
    input  logic [OPCODE_WIDTH+TAG_WIDTH+DATA_WIDTH-1:0] vector_in,
    output logic [DATA_WIDTH-1:0]                     data_out,
    output logic [DATA_WIDTH-1:0]                     data_out_miss,
    output logic [TAG_WIDTH-1:0]                      tag_out_miss,
`ifdef CACHE_STATS_EN
    output logic [15:0]                               hit_count,
    output logic [15:0]                               miss_count,
`endif
    output logic                                      hit_miss_out
);

    localparam int                    c_idx_width = $clog2(ENTRIES_WIDTH);
    localparam int                    c_op_lsb    = opcode_lsb(TAG_WIDTH, DATA_WIDTH);
    localparam int                    c_tag_lsb   = tag_lsb(DATA_WIDTH);
    localparam int                    c_data_lsb  = data_lsb();
    localparam logic [c_idx_width-1:0] c_last_idx = c_idx_width'(ENTRIES_WIDTH - 1);

    logic [ENTRIES_WIDTH-1:0]                 r_valid;
    logic [ENTRIES_WIDTH-1:0][TAG_WIDTH-1:0]  r_tags;
    logic [ENTRIES_WIDTH-1:0][DATA_WIDTH-1:0] r_data;
    logic [c_idx_width-1:0]                   r_ptr;

    logic [DATA_WIDTH-1:0] r_data_out;
    logic [DATA_WIDTH-1:0] r_data_out_miss;
    logic [TAG_WIDTH-1:0]  r_tag_out_miss;
    logic                  r_hit;

    logic [OPCODE_WIDTH-1:0] w_opcode;
    logic [TAG_WIDTH-1:0]    w_tag;
    logic [DATA_WIDTH-1:0]   w_data;
    logic                    w_hit;
    logic [c_idx_width-1:0]  w_hit_idx;
    logic                    w_free;
    logic [c_idx_width-1:0]  w_free_idx;
    logic [c_idx_width-1:0]  w_wr_idx;
    logic [c_idx_width-1:0]  w_ptr_next;
    logic                    w_exec;

    assign w_opcode = vector_in[c_op_lsb +: OPCODE_WIDTH];
    assign w_tag    = vector_in[c_tag_lsb +: TAG_WIDTH];
    assign w_data   = vector_in[c_data_lsb +: DATA_WIDTH];
    assign w_exec   = rst_n && !enable;

    cache_match #(
        .TAG_WIDTH     (TAG_WIDTH),
        .ENTRIES_WIDTH (ENTRIES_WIDTH)
    ) u_match (
        .i_valid            (r_valid),
        .i_tags             (r_tags),
        .i_lookup_tag       (w_tag),
        .o_hit              (w_hit),
        .o_hit_index        (w_hit_idx),
        .o_free_found       (w_free),
        .o_first_free_index (w_free_idx)
    );

    // Write target: in-place on hit, else lowest free slot, else the victim
    always_comb begin
        w_wr_idx   = w_hit ? w_hit_idx : (w_free ? w_free_idx : r_ptr);
        w_ptr_next = (r_ptr == c_last_idx) ? '0 : r_ptr + 1'b1;
    end

    // Tag/data storage; contents are meaningless until the valid bit is set
    always_ff @(posedge clk) begin
        if (w_exec && (w_opcode == OP_WRITE)) begin
            r_tags[w_wr_idx] <= w_tag;
            r_data[w_wr_idx] <= w_data;
        end
    end

    // Command execution: valid bits, replacement pointer and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid         <= '0;
            r_ptr           <= '0;
            r_data_out      <= '0;
            r_data_out_miss <= '0;
            r_tag_out_miss  <= '0;
            r_hit           <= 1'b0;
        end else if (!enable) begin
            r_hit           <= 1'b0;
            r_data_out_miss <= '0;
            r_tag_out_miss  <= '0;
            case (w_opcode)
                OP_READ: begin
                    if (w_hit) begin
                        r_hit      <= 1'b1;
                        r_data_out <= r_data[w_hit_idx];
                    end else begin
                        r_data_out     <= '0;
                        r_tag_out_miss <= w_tag;
                    end
                end
                OP_WRITE: begin
                    if (w_hit) begin
                        r_hit <= 1'b1;
                    end else if (w_free) begin
                        r_valid[w_free_idx] <= 1'b1;
                    end else begin
                        r_tag_out_miss  <= r_tags[r_ptr];
                        r_data_out_miss <= r_data[r_ptr];
                        r_ptr           <= w_ptr_next;
                    end
                end
                OP_FLUSH: begin
                    r_valid <= '0;
                    r_ptr   <= '0;
                end
                default: ;
            endcase
        end
    end

    assign data_out      = r_data_out;
    assign data_out_miss = r_data_out_miss;
    assign tag_out_miss  = r_tag_out_miss;
    assign hit_miss_out  = r_hit;

`ifdef CACHE_STATS_EN
    logic [15:0] r_hit_count;
    logic [15:0] r_miss_count;

    // Saturating hit/miss counters; only reset clears them, FLUSH does not
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else if (!enable && ((w_opcode == OP_READ) || (w_opcode == OP_WRITE))) begin
            if (w_hit) begin
                if (r_hit_count != 16'hFFFF) r_hit_count <= r_hit_count + 16'd1;
            end else begin
                if (r_miss_count != 16'hFFFF) r_miss_count <= r_miss_count + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule : cache
`default_nettype wire

// File: tb/tb_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache
// Description : Self-checking bench for cache: table of directed vectors
//               plus hand-written stall and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache;

    localparam logic [1:0] c_flush = 2'b00;
    localparam logic [1:0] c_read  = 2'b01;
    localparam logic [1:0] c_write = 2'b10;
    localparam logic [1:0] c_nop   = 2'b11;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [25:0] vector_in;
    logic [15:0] data_out;
    logic [15:0] data_out_miss;
    logic [7:0]  tag_out_miss;
    logic        hit_miss_out;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    int n_vec;
    int n_bad;

    typedef struct {
        logic [1:0]  op;
        logic [7:0]  tag;
        logic [15:0] data;
        logic        hit;
        logic [15:0] dout;
        logic [7:0]  tmiss;
        logic [15:0] dmiss;
    } vec_t;

    vec_t vecs[$];

    cache dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .enable        (enable),
        .vector_in     (vector_in),
        .data_out      (data_out),
        .data_out_miss (data_out_miss),
        .tag_out_miss  (tag_out_miss),
`ifdef CACHE_STATS_EN
        .hit_count     (hit_count),
        .miss_count    (miss_count),
`endif
        .hit_miss_out  (hit_miss_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic add(input logic [1:0] op, input logic [7:0] tag, input logic [15:0] data,
                       input logic hit, input logic [15:0] dout,
                       input logic [7:0] tmiss, input logic [15:0] dmiss);
        vec_t v;
        v.op = op; v.tag = tag; v.data = data;
        v.hit = hit; v.dout = dout; v.tmiss = tmiss; v.dmiss = dmiss;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, clock once, then compare all outputs
    task automatic apply(input string name, input int idx, input logic en, input logic rn,
                         input logic [1:0] op, input logic [7:0] tag, input logic [15:0] data,
                         input logic hit, input logic [15:0] dout,
                         input logic [7:0] tmiss, input logic [15:0] dmiss);
        enable    = en;
        rst_n     = rn;
        vector_in = {op, tag, data};
        @(posedge clk);
        #1;
        n_vec++;
        if (hit_miss_out !== hit || data_out !== dout ||
            tag_out_miss !== tmiss || data_out_miss !== dmiss) begin
            n_bad++;
            $display("FAIL %s[%0d]: got hit=%0b dout=%h tmiss=%h dmiss=%h, want hit=%0b dout=%h tmiss=%h dmiss=%h",
                     name, idx, hit_miss_out, data_out, tag_out_miss, data_out_miss,
                     hit, dout, tmiss, dmiss);
        end
    endtask

    initial begin
        logic [25:0] flush_word;
        n_vec = 0;
        n_bad = 0;
        enable    = 1'b0;
        rst_n     = 1'b0;
        vector_in = {c_nop, 8'h00, 16'h0000};

        // Fill: 64 distinct tags, no eviction, data_out still 0 from reset
        for (int i = 0; i < 64; i++)
            add(c_write, 8'(i), (i == 0) ? 16'hFFFF : 16'(i - 1), 1'b0, 16'h0000, 8'h00, 16'h0000);
        // Read back every entry
        for (int i = 0; i < 64; i++)
            add(c_read, 8'(i), 16'h0000, 1'b1, (i == 0) ? 16'hFFFF : 16'(i - 1), 8'h00, 16'h0000);
        // 65th distinct write evicts entry 0, next evicts entry 1
        add(c_write, 8'hFF, 16'h1111, 1'b0, 16'h003E, 8'h00, 16'hFFFF);
        add(c_write, 8'hFE, 16'h2222, 1'b0, 16'h003E, 8'h01, 16'h0000);
        add(c_read,  8'hFF, 16'h0000, 1'b1, 16'h1111, 8'h00, 16'h0000);
        add(c_read,  8'hFE, 16'h0000, 1'b1, 16'h2222, 8'h00, 16'h0000);
        add(c_read,  8'h00, 16'h0000, 1'b0, 16'h0000, 8'h00, 16'h0000);
        add(c_read,  8'h01, 16'h0000, 1'b0, 16'h0000, 8'h01, 16'h0000);
        add(c_read,  8'h0F, 16'h0000, 1'b1, 16'h000E, 8'h00, 16'h0000);
        for (int i = 0; i < 4; i++)
            add(c_read, 8'h0A, 16'h0000, 1'b1, 16'h0009, 8'h00, 16'h0000);
        // Flush with non-zero tag/data fields; data_out holds
        flush_word = 26'b00_00110001_0000000000000001;
        add(flush_word[25:24], flush_word[23:16], flush_word[15:0], 1'b0, 16'h0009, 8'h00, 16'h0000);
        for (int i = 0; i < 8; i++)
            add(c_read, 8'(i), 16'h0000, 1'b0, 16'h0000, 8'(i), 16'h0000);
        // Allocate, overwrite in place, read back next cycle, then NOP
        add(c_write, 8'h05, 16'hAAAA, 1'b0, 16'h0000, 8'h00, 16'h0000);
        add(c_write, 8'h05, 16'hBBBB, 1'b1, 16'h0000, 8'h00, 16'h0000);
        add(c_read,  8'h05, 16'h0000, 1'b1, 16'hBBBB, 8'h00, 16'h0000);
        add(c_nop,   8'h05, 16'h1234, 1'b0, 16'hBBBB, 8'h00, 16'h0000);

        // Reset state
        apply("reset", 0, 1'b0, 1'b0, c_read, 8'h00, 16'h0000, 1'b0, 16'h0000, 8'h00, 16'h0000);
        apply("reset", 1, 1'b0, 1'b0, c_nop,  8'h00, 16'h0000, 1'b0, 16'h0000, 8'h00, 16'h0000);

        for (int i = 0; i < vecs.size(); i++)
            apply("vec", i, 1'b0, 1'b1, vecs[i].op, vecs[i].tag, vecs[i].data,
                  vecs[i].hit, vecs[i].dout, vecs[i].tmiss, vecs[i].dmiss);

        // Stall: outputs hold the last read-hit, the stalled write is dropped
        apply("pre_stall", 0, 1'b0, 1'b1, c_read,  8'h05, 16'h0000, 1'b1, 16'hBBBB, 8'h00, 16'h0000);
        apply("stall",     0, 1'b1, 1'b1, c_write, 8'h77, 16'h1234, 1'b1, 16'hBBBB, 8'h00, 16'h0000);
        apply("stall",     1, 1'b1, 1'b1, c_read,  8'h77, 16'h0000, 1'b1, 16'hBBBB, 8'h00, 16'h0000);
        apply("post_stall",0, 1'b0, 1'b1, c_read,  8'h77, 16'h0000, 1'b0, 16'h0000, 8'h77, 16'h0000);
        apply("post_stall",1, 1'b0, 1'b1, c_read,  8'h05, 16'h0000, 1'b1, 16'hBBBB, 8'h00, 16'h0000);

        // Mid-sequence reset overrides enable and the pending command
        apply("mid_reset", 0, 1'b1, 1'b0, c_read, 8'h05, 16'h0000, 1'b0, 16'h0000, 8'h00, 16'h0000);
        apply("after_reset", 0, 1'b0, 1'b1, c_read, 8'h05, 16'h0000, 1'b0, 16'h0000, 8'h05, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_cache
`default_nettype wire

// File: doc/cache.md
Name: cache

Overview:
- Fully associative tag/data cache with 2^n-agnostic entry count (default 64); one command per clock via a packed `vector_in` word.
- Commands: read, write, flush and no-op.
- Reports hit/miss status, read data, and miss/eviction tag and data for a backing store or next cache level.
- Instantiated as a cache block beneath the memory-hierarchy top level.

Parameters:
- TAG_WIDTH, 8, width of tag field and of each stored tag.
- DATA_WIDTH, 16, width of data field and of each stored data word.
- ENTRIES_WIDTH, 64, number of cache entries (not a log2); legal range 2..256.
- OPCODE_WIDTH, 2, width of opcode field; fixed at 2.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- enable  in  1  stall. 1 = hold all state and outputs; 0 = normal operation.
- vector_in  in  OPCODE_WIDTH+TAG_WIDTH+DATA_WIDTH  command word = {opcode[MSBs], tag, data[LSBs]}.
- data_out  out  DATA_WIDTH  read-hit data.
- data_out_miss  out  DATA_WIDTH  evicted data on write-eviction, else 0.
- tag_out_miss  out  TAG_WIDTH  missed tag (read miss) or evicted tag (write-eviction), else 0.
- hit_miss_out  out  1  1 = hit, 0 = miss/other.

Behaviour:
- Opcode encoding:
  - 2'b00 FLUSH.
  - 2'b01 READ.
  - 2'b10 WRITE.
  - 2'b11 NOP.
- Sampling and latency:
  - `vector_in` is sampled every rising edge when rst_n=1 and enable=0.
  - All outputs are registered; results are visible 1 cycle after sampling.
  - One command per cycle.
- Reset, when rst_n=0 at a clock edge:
  - All valid bits cleared and replacement pointer = 0.
  - All outputs = 0.
  - Reset has priority over enable and over any command.
- Storage:
  - Per entry: valid bit, tag, data.
  - At most one valid entry per tag, at all times.
- Lookup: parallel compare of the tag against all valid entries.
- READ hit: data_out = stored data, hit_miss_out = 1, tag_out_miss = 0, data_out_miss = 0.
- READ miss: hit_miss_out = 0, tag_out_miss = requested tag, data_out_miss = 0, data_out = 0.
- WRITE, applied in priority order:
  1. Hit: overwrite data in place; hit_miss_out = 1; miss outputs = 0.
  2. Miss with a free entry: allocate the lowest-index invalid entry; hit_miss_out = 0; miss outputs = 0.
  3. Miss with cache full: evict the entry at the replacement pointer. tag_out_miss/data_out_miss = victim tag/data; new tag/data stored there; pointer increments, wrapping at ENTRIES_WIDTH-1 -> 0; hit_miss_out = 0.
  - data_out holds its previous value on every WRITE.
- FLUSH:
  - All valid bits cleared and replacement pointer = 0.
  - hit_miss_out = 0, miss outputs = 0; data_out holds.
  - The tag/data fields of the FLUSH command are ignored.
- NOP: no state change; hit_miss_out = 0; miss outputs = 0; data_out holds.
- enable=1: no command is executed, storage is unchanged, and all outputs keep their last values.
- Boundary cases:
  - Writing exactly ENTRIES_WIDTH distinct tags fills the cache with no eviction.
  - The (ENTRIES_WIDTH+1)th distinct write evicts entry 0.
  - A READ of a tag written the previous cycle hits; storage updates at the edge, so there are no hazards.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined:
  - Adds outputs hit_count[15:0] and miss_count[15:0].
  - Each READ/WRITE that executes increments exactly one of the two counters; counting saturates at 16'hFFFF.
  - Counters are cleared by reset only; FLUSH does not clear them.
- Undefined: the ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package cache_pkg:
  - Opcode constants OP_FLUSH, OP_READ, OP_WRITE, OP_NOP.
  - Default width constants.
  - Field-slice helper functions for opcode/tag/data positions in vector_in.
- Sub-module cache_match:
  - Combinational, parameterised by TAG_WIDTH/ENTRIES_WIDTH.
  - Inputs: valid vector, tag array, lookup tag.
  - Outputs: hit, hit_index, free_found, first_free_index (lowest index).
- Top module `cache`: storage, replacement pointer, command decode and output registers.

Test Plan:
- Fill: enable=0, WRITE tags 0x00..0x3F with data 0xFFFF, 0x0000, ... 0x003E -> every hit_miss_out=0, miss outputs 0, no eviction.
- Read back: READ tags 0x00..0x3F -> hit_miss_out=1, data_out = 0xFFFF for tag 0x00, then 0x0000..0x003E for tags 0x01..0x3F.
- Evict: from the full state, WRITE tag 0xFF data 0x1111 -> hit_miss_out=0, tag_out_miss=0x00, data_out_miss=0xFFFF.
  - Then READ 0xFF -> hit, 0x1111.
  - Then READ 0x00 -> miss, tag_out_miss=0x00.
  - Then READ 0x0F -> hit, 0x000E.
- Repeated read: READ tag 0x0A four consecutive cycles -> hit, data_out=0x0009 each cycle.
- Flush: FLUSH (vector_in=26'b00_00110001_0000000000000001), then READ tags 0x00..0x07 -> all hit_miss_out=0, tag_out_miss equal to each requested tag.
- Reset/stall:
  - enable=1 with a WRITE applied -> a later READ of that tag misses.
  - rst_n=0 mid-sequence -> all outputs 0 next cycle, and a prior hit tag now misses.
